// File: rtl/tx_resultado.sv
// ---------------------------------------------------------------------------
// tx_resultado
// Serial UART (8N1) transmitter for the controller product word. A one-cycle
// Tx_En strobe accepted in IDLE latches Dato, zero-extended to 32 bits, and
// the word leaves as four bytes, most-significant byte first and LSB first
// within each byte. The stop bit of one byte runs straight into the start bit
// of the next one.
//
// Ports
//   Clk_G    in   system clock, rising edge
//   Rst_G    in   synchronous active-high reset
//   Tx_En    in   start strobe, honoured only while idle
//   Dato     in   cant_bits-wide word to send
//   Tx       out  serial line, registered, idles high
//   Busy     out  high while a frame is in progress
//   Tx_Done  out  one-cycle pulse at the end of the last stop bit
// ---------------------------------------------------------------------------
module tx_resultado #(
  parameter int cant_bits    = 26,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 Clk_G,
  input  logic                 Rst_G,
  input  logic                 Tx_En,
  input  logic [cant_bits-1:0] Dato,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Tx_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [31:0]       word, word_nxt;
  logic              tx_r, tx_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic [7:0]        cur_byte;
  logic              bit_last;

  // Byte currently on the line; index 0 is the most significant byte.
  always_comb begin
    cur_byte = word[31:24];
    case (byte_idx)
      2'd0:    cur_byte = word[31:24];
      2'd1:    cur_byte = word[23:16];
      2'd2:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
  end

  assign bit_last = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state logic. Tx is computed one cycle ahead so that it comes out of
  // a flop together with the state that owns it.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    word_nxt     = word;
    tx_nxt       = tx_r;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (Tx_En) begin
          word_nxt     = 32'(Dato);
          byte_idx_nxt = 2'd0;
          cnt_nxt      = '0;
          state_nxt    = S_START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
        end
      end

      S_START: begin
        if (bit_last) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = S_DATA;
          tx_nxt      = cur_byte[0];
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_last) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin // S_STOP
        if (bit_last) begin
          cnt_nxt = '0;
          if (byte_idx != 2'd3) begin
            byte_idx_nxt = byte_idx + 2'd1;
            state_nxt    = S_START;
            tx_nxt       = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // State register; reset abandons any partial frame without a done pulse.
  always_ff @(posedge Clk_G) begin
    if (Rst_G) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      word     <= 32'd0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      word     <= word_nxt;
      tx_r     <= tx_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
    end
  end

  assign Tx      = tx_r;
  assign Busy    = busy_r;
  assign Tx_Done = done_r;

endmodule

// File: tb/tb_tx_resultado.sv
module tb_tx_resultado;

  localparam int CB  = 26;
  localparam int CPB = 4;
  localparam int FRAME = 40 * CPB;

  logic          Clk_G;
  logic          Rst_G;
  logic          Tx_En;
  logic [CB-1:0] Dato;
  logic          Tx;
  logic          Busy;
  logic          Tx_Done;

  int checks   = 0;
  int failures = 0;

  tx_resultado #(.cant_bits(CB), .CLKS_PER_BIT(CPB)) dut (
    .Clk_G   (Clk_G),
    .Rst_G   (Rst_G),
    .Tx_En   (Tx_En),
    .Dato    (Dato),
    .Tx      (Tx),
    .Busy    (Busy),
    .Tx_Done (Tx_Done)
  );

  initial Clk_G = 1'b0;
  always #5 Clk_G = ~Clk_G;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: line level k cycles after acceptance for a 32-bit word sent as
  // four 10-bit UART characters, MSB byte first, each bit CPB cycles long.
  function automatic logic line_at(input logic [31:0] w, input int k);
    int bitpos, byte_i, pos;
    bitpos = k / CPB;
    byte_i = bitpos / 10;
    pos    = bitpos % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[24 - 8 * byte_i + (pos - 1)];
  endfunction

  task automatic tick();
    @(posedge Clk_G);
    #1;
  endtask

  task automatic strobe(input logic [CB-1:0] d);
    Tx_En = 1'b1;
    Dato  = d;
  endtask

  // Runs one frame after strobe(): checks every cycle against the reference,
  // optionally pulses a competing Tx_En at ign_at or resets at rst_at, and
  // decodes the line mid-bit to compare the received word with exp_word.
  task automatic run(input string tag, input logic [31:0] exp_word,
                     input int ign_at, input int rst_at, input logic [CB-1:0] ign_d);
    logic [31:0] rx;
    int          bitpos, pos;
    rx = 32'd0;
    tick();
    Tx_En = 1'b0;
    Dato  = CB'($urandom);
    for (int k = 0; k < FRAME; k++) begin
      chk({tag, "_tx"}, 32'(Tx), 32'(line_at(exp_word, k)));
      if (k % CPB == 0) begin
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_done"}, 32'(Tx_Done), 32'd0);
      end
      if (k % CPB == CPB / 2) begin
        bitpos = k / CPB;
        pos    = bitpos % 10;
        if (pos >= 1 && pos <= 8)
          rx[24 - 8 * (bitpos / 10) + (pos - 1)] = Tx;
      end
      if (k == rst_at) begin
        Rst_G = 1'b1;
        tick();
        chk({tag, "_rst_tx"}, 32'(Tx), 32'd1);
        chk({tag, "_rst_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_rst_done"}, 32'(Tx_Done), 32'd0);
        Rst_G = 1'b0;
        tick();
        chk({tag, "_post_tx"}, 32'(Tx), 32'd1);
        chk({tag, "_post_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_post_done"}, 32'(Tx_Done), 32'd0);
        return;
      end
      if (k == ign_at) begin
        Tx_En = 1'b1;
        Dato  = ign_d;
      end else begin
        Tx_En = 1'b0;
      end
      tick();
    end
    Tx_En = 1'b0;
    chk({tag, "_end_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_end_done"}, 32'(Tx_Done), 32'd1);
    chk({tag, "_end_tx"}, 32'(Tx), 32'd1);
    chk({tag, "_word"}, rx, exp_word);
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, "_idle_done"}, 32'(Tx_Done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_idle_tx"}, 32'(Tx), 32'd1);
  endtask

  initial begin
    logic [CB-1:0] r;

    // Reset held two cycles with a pending strobe.
    Rst_G = 1'b1;
    Tx_En = 1'b1;
    Dato  = 26'h2ABCDEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_tx", 32'(Tx), 32'd1);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_done", 32'(Tx_Done), 32'd0);
    end
    Rst_G = 1'b0;
    Tx_En = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("after_reset_tx", 32'(Tx), 32'd1);
      chk("after_reset_busy", 32'(Busy), 32'd0);
    end

    // Directed single frame.
    strobe(26'h2ABCDEF);
    run("single", 32'h02ABCDEF, -1, -1, '0);
    idle_check("single");

    // Extremes.
    strobe(26'h0000000);
    run("zero", 32'h00000000, -1, -1, '0);
    idle_check("zero");
    strobe(26'h3FFFFFF);
    run("ones", 32'h03FFFFFF, -1, -1, '0);
    idle_check("ones");

    // Strobe while busy is ignored.
    strobe(26'h0000055);
    run("busy_ign", 32'h00000055, 50, -1, 26'h1234567);
    idle_check("busy_ign");

    // Back-to-back: new strobe in the Tx_Done cycle.
    strobe(26'h1111111);
    run("b2b_a", 32'h01111111, -1, -1, '0);
    strobe(26'h0000001);
    run("b2b_b", 32'h00000001, -1, -1, '0);
    idle_check("b2b");

    // Reset mid-frame, then a full frame.
    strobe(26'h2468ACE);
    run("midrst", 32'h02468ACE, -1, 70, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_quiet_tx", 32'(Tx), 32'd1);
      chk("midrst_quiet_busy", 32'(Busy), 32'd0);
    end
    strobe(26'h1357BDF);
    run("after_rst", 32'h01357BDF, -1, -1, '0);
    idle_check("after_rst");

    // Random words.
    for (int n = 0; n < 4; n++) begin
      r = CB'($urandom);
      strobe(r);
      run("rand", {6'd0, r}, -1, -1, '0);
      idle_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
